dunit_step_ctrl: RTL and testbench



---
 rtl/dunit_pkg.sv | 23 ++
 rtl/dunit_frame_ser.sv | 56 +++++
 rtl/dunit_step_ctrl.sv | 110 +++++++++++
 tb/tb_dunit_step_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dunit_pkg.sv
// Shared definitions for the debug unit: controller states, command codes and
// dump-frame geometry.
package dunit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_LOAD,
        ST_SEND,
        ST_HALTED
    } state_t;

    localparam logic [7:0] DUNIT_CMD_RUN  = 8'h43;
    localparam logic [7:0] DUNIT_CMD_STEP = 8'h53;
    localparam logic [7:0] DUNIT_CMD_DUMP = 8'h44;

    // Four full latch words plus one 16-bit padded control word.
    function automatic int frame_len(input int nb_reg);
        return 4 * nb_reg / 8 + 2;
    endfunction

endpackage

// File: rtl/dunit_frame_ser.sv
// Snapshot of the EX/MEM latch outputs and byte-wise serialiser that feeds
// the UART transmitter, MSB byte first.
module dunit_frame_ser
    import dunit_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_CTRL = 9,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               load,
    input  logic [NB_REG-1:0]  pc_eight,
    input  logic [NB_REG-1:0]  alu_result,
    input  logic [NB_REG-1:0]  w_data,
    input  logic [NB_REG-1:0]  data_addr,
    input  logic [NB_CTRL-1:0] control,
    input  logic               tx_valid,
    input  logic               tx_ready,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               last
);

    localparam int FRAME_LEN = frame_len(NB_REG);
    localparam int FRAME_W   = FRAME_LEN * NB_BYTE;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [FRAME_W-1:0] snap;
    logic [CNT_W-1:0]   cnt;

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            snap <= '0;
            cnt  <= '0;
        end else if (load) begin
            snap <= {pc_eight, alu_result, w_data, data_addr, 16'(control)};
            cnt  <= '0;
        end else if (tx_valid && tx_ready) begin
            // Wrap after the last byte so an idle serialiser always points at byte 0.
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (cnt == CNT_W'(i)) begin
                tx_data = snap[FRAME_W-1-i*NB_BYTE -: NB_BYTE];
            end
        end
    end

endmodule

// File: rtl/dunit_step_ctrl.sv
// Debug-unit pipeline controller: gates the pipeline latch enable from UART
// commands (run / step / dump) and dumps the EX/MEM latch after each stop.
module dunit_step_ctrl
    import dunit_pkg::*;
#(
    parameter int                 NB_REG   = 32,
    parameter int                 NB_CTRL  = 9,
    parameter int                 NB_BYTE  = 8,
    parameter logic [NB_BYTE-1:0] CMD_RUN  = DUNIT_CMD_RUN,
    parameter logic [NB_BYTE-1:0] CMD_STEP = DUNIT_CMD_STEP,
    parameter logic [NB_BYTE-1:0] CMD_DUMP = DUNIT_CMD_DUMP
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    input  logic               i_halt,
    input  logic [NB_REG-1:0]  i_pc_eight,
    input  logic [NB_REG-1:0]  i_alu_result,
    input  logic [NB_REG-1:0]  i_w_data,
    input  logic [NB_REG-1:0]  i_data_addr,
    input  logic [NB_CTRL-1:0] i_control_from_ex,
    output logic               o_dunit_clk_en
);

    state_t state, state_next;
    logic   halted, halted_next;
    logic   load;
    logic   last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    always_comb begin
        state_next  = state;
        halted_next = halted;
        load        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_RUN) begin
                        state_next = ST_RUN;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_next = ST_STEP;
                    end else if (i_rx_data == CMD_DUMP) begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_RUN: begin
                // The edge that samples halt still advances the pipeline.
                if (i_halt) begin
                    state_next  = ST_LOAD;
                    halted_next = 1'b1;
                end
            end
            ST_STEP: state_next = ST_LOAD;
            ST_LOAD: begin
                load       = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (i_tx_ready && last) begin
                    state_next = halted ? ST_HALTED : ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (i_rx_valid && i_rx_data == CMD_DUMP) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_dunit_clk_en = (state == ST_RUN) || (state == ST_STEP);
    assign o_rx_ready     = (state == ST_IDLE) || (state == ST_HALTED);
    assign o_tx_valid     = (state == ST_SEND);

    dunit_frame_ser #(
        .NB_REG  (NB_REG),
        .NB_CTRL (NB_CTRL),
        .NB_BYTE (NB_BYTE)
    ) u_frame_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .load       (load),
        .pc_eight   (i_pc_eight),
        .alu_result (i_alu_result),
        .w_data     (i_w_data),
        .data_addr  (i_data_addr),
        .control    (i_control_from_ex),
        .tx_valid   (o_tx_valid),
        .tx_ready   (i_tx_ready),
        .tx_data    (o_tx_data),
        .last       (last)
    );

endmodule

// File: tb/tb_dunit_step_ctrl.sv
// Scoreboard bench for dunit_step_ctrl: expected dump frames are queued when
// commands are issued and a monitor checks every transferred byte.
module tb_dunit_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [31:0] pc_eight, alu_result, w_data, data_addr;
    logic [8:0]  control;
    logic        clk_en;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    int          en_cnt  = 0;
    int          vld_cnt = 0;
    int          sent    = 0;
    int          ready_mode = 0;
    logic        hold_vld = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    dunit_step_ctrl dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_rx_data         (rx_data),
        .i_rx_valid        (rx_valid),
        .o_rx_ready        (rx_ready),
        .o_tx_data         (tx_data),
        .o_tx_valid        (tx_valid),
        .i_tx_ready        (tx_ready),
        .i_halt            (halt),
        .i_pc_eight        (pc_eight),
        .i_alu_result      (alu_result),
        .i_w_data          (w_data),
        .i_data_addr       (data_addr),
        .i_control_from_ex (control),
        .o_dunit_clk_en    (clk_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: four words MSB byte first, then control zero-padded to 16 bits.
    function automatic void push_frame();
        logic [31:0] words[4];
        logic [15:0] c16;
        words[0] = pc_eight; words[1] = alu_result;
        words[2] = w_data;   words[3] = data_addr;
        for (int w = 0; w < 4; w++)
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
        c16 = 16'(control);
        exp_q.push_back(c16 / 256);
        exp_q.push_back(c16 % 256);
    endfunction

    task automatic randomize_latch();
        pc_eight   = $urandom;
        alu_result = $urandom;
        w_data     = $urandom;
        data_addr  = $urandom;
        control    = 9'($urandom);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        while (!rx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) check("cmd_accept_timeout", 32'(rx_ready), 32'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || tx_valid) && t < 600) begin
            @(negedge clk);
            t++;
        end
        check("frame_done_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // tx_ready driver
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a byte is transferred on the next edge when valid & ready.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (clk_en) en_cnt++;
            if (!reset && tx_valid) begin
                vld_cnt++;
                if (hold_vld) check("tx_hold", 32'(tx_data), 32'(hold_data));
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                    sent++;
                    hold_vld = 1'b0;
                end else begin
                    hold_vld  = 1'b1;
                    hold_data = tx_data;
                end
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, v0, s0, t;
        logic [7:0] cmd;
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; halt = 1'b0;
        pc_eight = '0; alu_result = '0; w_data = '0; data_addr = '0; control = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_clk_en",   32'(clk_en),   32'd0);
        check("reset_rx_ready", 32'(rx_ready), 32'd1);
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_tx_data",  32'(tx_data),  32'h00);
        repeat (3) @(negedge clk);
        check("idle_clk_en", 32'(clk_en), 32'd0);

        // Directed single step
        pc_eight = 32'h0000_0008; alu_result = 32'h1234_5678;
        w_data = $urandom; data_addr = $urandom; control = 9'h1A5;
        e0 = en_cnt;
        push_frame();
        send_cmd(8'h53);
        check("step_rx_ready_low", 32'(rx_ready), 32'd0);
        wait_done();
        check("step_en_cycles", 32'(en_cnt - e0), 32'd1);

        // Dump with toggling ready, latch inputs change mid-frame
        ready_mode = 1;
        randomize_latch();
        e0 = en_cnt; s0 = sent;
        push_frame();
        send_cmd(8'h44);
        t = 0;
        while (sent < s0 + 5 && t < 100) begin @(negedge clk); t++; end
        randomize_latch();
        wait_done();
        check("dump_en_cycles", 32'(en_cnt - e0), 32'd0);
        check("dump_bytes", 32'(sent - s0), 32'd18);
        ready_mode = 0;

        // Reset while byte 7 is on the wire
        randomize_latch();
        s0 = sent;
        push_frame();
        send_cmd(8'h44);
        t = 0;
        @(negedge clk);
        while (sent < s0 + 7 && t < 100) begin @(negedge clk); t++; end
        check("pre_reset_bytes", 32'(sent - s0), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("midreset_tx_valid", 32'(tx_valid), 32'd0);
        check("midreset_tx_data",  32'(tx_data),  32'h00);
        check("midreset_rx_ready", 32'(rx_ready), 32'd1);
        check("midreset_clk_en",   32'(clk_en),   32'd0);
        randomize_latch();
        push_frame();
        send_cmd(8'h44);
        wait_done();

        // Unknown byte in IDLE
        e0 = en_cnt; v0 = vld_cnt;
        send_cmd(8'h7F);
        repeat (4) @(negedge clk);
        check("unknown_en", 32'(en_cnt - e0), 32'd0);
        check("unknown_tx", 32'(vld_cnt - v0), 32'd0);
        check("unknown_rx_ready", 32'(rx_ready), 32'd1);

        // Randomised step / dump / junk commands with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            randomize_latch();
            case ($urandom_range(0, 2))
                0: cmd = 8'h53;
                1: cmd = 8'h44;
                default: begin
                    cmd = 8'($urandom);
                    if (cmd == 8'h43 || cmd == 8'h53 || cmd == 8'h44) cmd = 8'h00;
                end
            endcase
            e0 = en_cnt; v0 = vld_cnt;
            if (cmd == 8'h53 || cmd == 8'h44) push_frame();
            send_cmd(cmd);
            repeat (2) @(negedge clk);
            wait_done();
            check("rand_en", 32'(en_cnt - e0), (cmd == 8'h53) ? 32'd1 : 32'd0);
            if (cmd != 8'h53 && cmd != 8'h44) check("rand_junk_tx", 32'(vld_cnt - v0), 32'd0);
        end
        ready_mode = 0;

        // Continuous run until halt
        randomize_latch();
        e0 = en_cnt;
        send_cmd(8'h43);
        check("run_rx_ready_low", 32'(rx_ready), 32'd0);
        check("run_clk_en", 32'(clk_en), 32'd1);
        repeat (20) @(negedge clk);
        push_frame();
        halt = 1'b1;
        @(negedge clk);
        check("halt_clk_en_low", 32'(clk_en), 32'd0);
        wait_done();
        check("run_en_cycles", 32'(en_cnt - e0), 32'd21);
        check("halted_rx_ready", 32'(rx_ready), 32'd1);

        // HALTED ignores run, honours dump
        e0 = en_cnt; v0 = vld_cnt;
        send_cmd(8'h43);
        repeat (5) @(negedge clk);
        check("halted_run_ignored_en", 32'(en_cnt - e0), 32'd0);
        check("halted_run_ignored_tx", 32'(vld_cnt - v0), 32'd0);
        check("halted_still_ready", 32'(rx_ready), 32'd1);
        randomize_latch();
        s0 = sent;
        push_frame();
        send_cmd(8'h44);
        wait_done();
        check("halted_dump_bytes", 32'(sent - s0), 32'd18);
        check("halted_dump_en", 32'(en_cnt - e0), 32'd0);
        check("halted_after_dump_ready", 32'(rx_ready), 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
